dsp_chain_sop_n: RTL and testbench

Parametrised, pipelined chain of signed two-term sum-of-products stages: each stage computes ax·ay + bx·by and adds it to the cascade from the previous stage. The result is the full dot product of all STAGES input pairs, tagged with a valid bit. An optional run-time accumulator sums results across successive beats. It is the next-generation replacement for the fixed four-stage int SOP-2 chain in the DSP proxy benchmarks.

---
 rtl/dsp_chain_sop_n.sv | 150 +++++++++++++++
 tb/tb_dsp_chain_sop_n.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp_chain_sop_n.sv
// Pipelined cascade of signed SOP-2 stages (dot product) with an optional run-time accumulator.
// Define DSP_CHAIN_SOP_SAT_EN to saturate accumulator/result writes instead of wrapping at RW bits.

module dsp_chain_sop_n #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned AW     = 18,
  parameter int unsigned BW     = 19,
  parameter int unsigned RW     = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [STAGES*AW-1:0] ax,
  input  logic [STAGES*AW-1:0] bx,
  input  logic [STAGES*BW-1:0] ay,
  input  logic [STAGES*BW-1:0] by,
  input  logic                 acc_en,
  input  logic                 acc_first,
  output logic                 out_valid,
  output logic signed [RW-1:0] result
);

  localparam int unsigned PW = AW + BW + 1;
  localparam int unsigned CW = PW + $clog2(STAGES);
  localparam int unsigned SW = ((RW > CW) ? RW : CW) + 1;
  localparam int unsigned OW = 2 * AW + 2 * BW;

  logic signed [CW-1:0] chain_w [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [OW-1:0]        ops_in, ops;
    logic signed [AW-1:0] ax_s, bx_s;
    logic signed [BW-1:0] ay_s, by_s;
    logic signed [PW-1:0] prod_d, prod_q;
    logic signed [CW-1:0] chain_prev, chain_d, chain_q;

    assign ops_in = {ax[k*AW +: AW], bx[k*AW +: AW], ay[k*BW +: BW], by[k*BW +: BW]};

    // Stage k waits k cycles so it meets the cascade of the same beat.
    if (k == 0) begin : g_direct
      assign ops = ops_in;
    end else begin : g_skew
      logic [OW-1:0] skew_d [k];
      logic [OW-1:0] skew_q [k];

      always_comb begin
        skew_d[0] = ops_in;
        for (int j = 1; j < k; j++) skew_d[j] = skew_q[j-1];
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) skew_q <= '{default: '0};
        else        skew_q <= skew_d;
      end

      assign ops = skew_q[k-1];
    end

    assign {ax_s, bx_s, ay_s, by_s} = ops;

    if (k == 0) begin : g_first
      assign chain_prev = '0;
    end else begin : g_next
      assign chain_prev = chain_w[k-1];
    end

    always_comb begin
      prod_d  = PW'(ax_s) * PW'(ay_s) + PW'(bx_s) * PW'(by_s);
      chain_d = chain_prev + CW'(prod_q);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        prod_q  <= '0;
        chain_q <= '0;
      end else begin
        prod_q  <= prod_d;
        chain_q <= chain_d;
      end
    end

    assign chain_w[k] = chain_q;
  end

  // Tags: index 0 aligns with the stage-0 product register, index STAGES with the last chain reg.
  logic [STAGES:0] vld_d, vld_q, en_d, en_q, first_d, first_q;

  always_comb begin
    vld_d   = {vld_q[STAGES-1:0], in_valid};
    en_d    = {en_q[STAGES-1:0], acc_en};
    first_d = {first_q[STAGES-1:0], acc_first};
  end

`ifdef DSP_CHAIN_SOP_SAT_EN
  localparam logic signed [SW-1:0] SatMax = {{(SW - RW + 1){1'b0}}, {(RW - 1){1'b1}}};
  localparam logic signed [SW-1:0] SatMin = {{(SW - RW + 1){1'b1}}, {(RW - 1){1'b0}}};

  function automatic logic signed [RW-1:0] fit(input logic signed [SW-1:0] v);
    if (v > SatMax)      return RW'(SatMax);
    else if (v < SatMin) return RW'(SatMin);
    else                 return RW'(v);
  endfunction
`else
  function automatic logic signed [RW-1:0] fit(input logic signed [SW-1:0] v);
    return RW'(v);
  endfunction
`endif

  logic signed [RW-1:0] acc_d, acc_q, result_d, result_q;
  logic                 out_valid_d, out_valid_q;
  logic signed [SW-1:0] chain_ext, acc_ext;

  always_comb begin
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = vld_q[STAGES];
    chain_ext   = SW'(chain_w[STAGES-1]);
    acc_ext     = SW'(acc_q);
    if (vld_q[STAGES]) begin
      if (en_q[STAGES]) begin
        acc_d    = first_q[STAGES] ? fit(chain_ext) : fit(acc_ext + chain_ext);
        result_d = acc_d;
      end else begin
        result_d = fit(chain_ext);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q       <= '0;
      en_q        <= '0;
      first_q     <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      en_q        <= en_d;
      first_q     <= first_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_dsp_chain_sop_n.sv
// Table-driven bench for dsp_chain_sop_n: latency, streaming with gaps, extremes, accumulation,
// saturation/wrap at RW=40, and asynchronous mid-stream reset.

module tb_dsp_chain_sop_n;

  localparam int S  = 4;
  localparam int AW = 18;
  localparam int BW = 19;
  localparam int RW = 40;

  localparam longint P38 = 64'sd274877906944;
  localparam longint P39 = 64'sd549755813888;

  typedef struct {
    bit             vld;
    logic [S*AW-1:0] ax, bx;
    logic [S*BW-1:0] ay, by;
    bit             en, first;
    longint         exp;
  } vec_t;

  logic                 clk, reset, in_valid, acc_en, acc_first, out_valid;
  logic [S*AW-1:0]      ax, bx;
  logic [S*BW-1:0]      ay, by;
  logic signed [RW-1:0] result;

  int   n_chk, n_bad;
  vec_t tbl[$];

  dsp_chain_sop_n #(.STAGES(S), .AW(AW), .BW(BW), .RW(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .ax        (ax),
    .bx        (bx),
    .ay        (ay),
    .by        (by),
    .acc_en    (acc_en),
    .acc_first (acc_first),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Uniform operands on every stage (all_st=1) or on stage 0 only.
  function automatic vec_t mk(input bit vld, input int a, input int b, input int c, input int d,
                              input bit all_st, input bit en, input bit first, input longint exp);
    vec_t v;
    v.vld = vld; v.ax = '0; v.bx = '0; v.ay = '0; v.by = '0;
    for (int k = 0; k < S; k++) begin
      if (all_st || k == 0) begin
        v.ax[k*AW +: AW] = a[AW-1:0];
        v.bx[k*AW +: AW] = b[AW-1:0];
        v.ay[k*BW +: BW] = c[BW-1:0];
        v.by[k*BW +: BW] = d[BW-1:0];
      end
    end
    v.en = en; v.first = first; v.exp = exp;
    return v;
  endfunction

  function automatic longint ref_dot(input vec_t v);
    longint s;
    logic signed [AW-1:0] a, b;
    logic signed [BW-1:0] c, d;
    s = 0;
    for (int k = 0; k < S; k++) begin
      a = v.ax[k*AW +: AW]; b = v.bx[k*AW +: AW];
      c = v.ay[k*BW +: BW]; d = v.by[k*BW +: BW];
      s += longint'(a) * longint'(c) + longint'(b) * longint'(d);
    end
    return s;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    logic [31:0] r;
    v.vld = 1'b1; v.en = 1'b0; v.first = 1'b0;
    for (int k = 0; k < S; k++) begin
      r = $urandom; v.ax[k*AW +: AW] = r[AW-1:0];
      r = $urandom; v.bx[k*AW +: AW] = r[AW-1:0];
      r = $urandom; v.ay[k*BW +: BW] = r[BW-1:0];
      r = $urandom; v.by[k*BW +: BW] = r[BW-1:0];
    end
    v.exp = ref_dot(v);
    return v;
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.vld; ax = v.ax; bx = v.bx; ay = v.ay; by = v.by;
    acc_en = v.en; acc_first = v.first;
  endtask

  task automatic idle();
    in_valid = 1'b0; acc_en = 1'b0; acc_first = 1'b0;
  endtask

  // Entry i is driven in cycle i; its output must appear exactly in cycle i+S+2, nothing else.
  task automatic run_table(input string nm);
    int n;
    int i;
    n = tbl.size();
    for (int c = 0; c < n + S + 5; c++) begin
      @(negedge clk);
      i = c - (S + 2);
      if (i >= 0 && i < n && tbl[i].vld) begin
        chk($sformatf("%s out_valid c%0d", nm, c), 64'(out_valid), 1);
        chk($sformatf("%s result c%0d", nm, c), result, tbl[i].exp);
      end else begin
        chk($sformatf("%s out_valid c%0d", nm, c), 64'(out_valid), 0);
      end
      if (c < n) drive(tbl[c]);
      else       idle();
    end
    tbl.delete();
  endtask

  initial begin
    longint sat_exp[4];
    n_chk = 0; n_bad = 0;
    clk = 1'b0; reset = 1'b1;
    ax = '0; bx = '0; ay = '0; by = '0;
    idle();

    #2 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("reset out_valid c%0d", c), 64'(out_valid), 0);
      chk($sformatf("reset result c%0d", c), result, 0);
      drive(mk(1, 1, 1, 2, 2, 1, 1, 1, 16));
    end
    @(negedge clk);
    idle();
    reset = 1'b1;

    tbl.push_back(mk(1, 1, 1, 2, 2, 1, 0, 0, 16));
    run_table("latency");

    for (int k = 0; k < 10; k++) tbl.push_back(rnd_vec());
    tbl.push_back(mk(0, 9, 9, 9, 9, 1, 0, 0, 0));
    tbl.push_back(mk(0, 9, 9, 9, 9, 1, 0, 0, 0));
    tbl.push_back(rnd_vec());
    tbl.push_back(rnd_vec());
    run_table("stream");

    tbl.push_back(mk(1, -131072, -131072, -262144, -262144, 1, 0, 0, P38));
    tbl.push_back(mk(1, 3, -4, 5, 6, 1, 0, 0, -36));
    tbl.push_back(mk(1, 131071, -131072, 262143, 262143, 1, 0, 0, -4 * 64'sd262143));
    run_table("extremes");

    tbl.push_back(mk(1, 5, 0, 1, 0, 0, 1, 1, 5));
    tbl.push_back(mk(1, 7, 0, 1, 0, 0, 1, 0, 12));
    tbl.push_back(mk(1, -3, 0, 1, 0, 0, 1, 0, 9));
    tbl.push_back(mk(1, 4, 0, 1, 0, 0, 1, 1, 4));
    tbl.push_back(mk(0, 50, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 100, 0, 1, 0, 0, 0, 1, 100));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 5));
    run_table("accum");

`ifdef DSP_CHAIN_SOP_SAT_EN
    sat_exp = '{P38, P39 - 1, P39 - 1, P39 - 1};
`else
    sat_exp = '{P38, -P39, -P38, 0};
`endif
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, -131072, -131072, -262144, -262144, 1, 1, (k == 0), sat_exp[k]));
    run_table("sat");

    tbl.push_back(mk(1, 5, 0, 1, 0, 0, 1, 1, 5));
    run_table("pre_reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(mk(1, 2, 0, 1, 0, 0, 0, 0, 2));
    end
    @(negedge clk);
    idle();
    chk("held result before reset", result, 5);
    #2 reset = 1'b0;
    #1;
    chk("async reset out_valid", 64'(out_valid), 0);
    chk("async reset result", result, 0);
    @(negedge clk);
    chk("in reset out_valid", 64'(out_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    tbl.push_back(mk(1, 2, 0, 3, 0, 0, 1, 0, 6));
    run_table("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
